// File: rtl/regfile_scoreboard.sv
// Decode-stage register file (NUM_RD comb reads, NUM_WR writes) with pending-write scoreboard.
// Latency: reads 0 cycles (optional same-cycle write bypass), writes and busy updates 1 cycle.
// Backpressure: issue_stall holds ID while a source or destination has an outstanding long producer.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rs_addr,
    output logic [NUM_RD*XLEN-1:0]   rs_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_rs_use,
    input  logic                     issue_rd_we,
    input  logic [AW-1:0]            issue_rd,
    input  logic                     issue_long,
    input  logic                     flush,
    output logic                     issue_stall,
    output logic [NREGS-1:0]         busy,
    output logic [AW:0]              pending_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] blocked;
    logic [AW-1:0]    rd_addr;
    logic [XLEN-1:0]  rd_word;
    logic [AW-1:0]    wa;
    logic             issue_accept;

    // Merge write ports into next register state; later ports overwrite earlier ones.
    always_comb begin
        wa     = '0;
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int i = 0; i < NUM_WR; i++) begin
            wa = wr_addr[i*AW +: AW];
            if (wr_en[i] && wa != '0) begin
                regs_d[wa] = wr_data[i*XLEN +: XLEN];
                wr_hit[wa] = 1'b1;
            end
        end
    end

    // Combinational read ports; x0 always reads zero, even when a port targets it.
    always_comb begin
        rs_data = '0;
        rd_addr = '0;
        rd_word = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr = rs_addr[p*AW +: AW];
            rd_word = regs_q[rd_addr];
            if (BYPASS != 0) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_en[i] && wr_addr[i*AW +: AW] == rd_addr) begin
                        rd_word = wr_data[i*XLEN +: XLEN];
                    end
                end
            end
            if (rd_addr == '0) begin
                rd_word = '0;
            end
            rs_data[p*XLEN +: XLEN] = rd_word;
        end
    end

    // Issue hazard check and scoreboard next state; a new long producer beats a same-cycle clear.
    always_comb begin
        blocked = (BYPASS != 0) ? (busy_q & ~wr_hit) : busy_q;
        blocked[0] = 1'b0;
        issue_stall = issue_valid &&
                      ((blocked[rs_addr[0 +: AW]] && issue_rs_use[0]) ||
                       (blocked[rs_addr[AW +: AW]] && issue_rs_use[1]) ||
                       (blocked[issue_rd] && issue_rd_we));
        issue_accept = issue_valid && !issue_stall && !flush;
        busy_d = busy_q & ~wr_hit;
        if (flush) begin
            busy_d = '0;
        end else if (issue_accept && issue_rd_we && issue_long && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Count of outstanding long producers, from the registered busy bits.
    always_comb begin
        pending_cnt = '0;
        for (int r = 0; r < NREGS; r++) begin
            pending_cnt = pending_cnt + {{AW{1'b0}}, busy_q[r]};
        end
    end

    assign busy = busy_q;

    // State registers; synchronous reset overrides writes, issue and flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one BYPASS=1 and one BYPASS=0 instance on shared inputs.
// Vectors drive inputs after a posedge, check combinational outputs before the next edge,
// then check registered busy/pending_cnt after that edge.
module tb_regfile_scoreboard;

    localparam logic [31:0] A  = 32'hAAAA_0001;
    localparam logic [31:0] B  = 32'hBBBB_0002;
    localparam logic [31:0] DE = 32'h0000_DEAD;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data1, rs_data0;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_valid;
    logic [1:0]  issue_rs_use;
    logic        issue_rd_we;
    logic [4:0]  issue_rd;
    logic        issue_long;
    logic        flush;
    logic        stall1, stall0;
    logic [31:0] busy1, busy0;
    logic [5:0]  cnt1, cnt0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut1 (
        .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rs_use(issue_rs_use), .issue_rd_we(issue_rd_we),
        .issue_rd(issue_rd), .issue_long(issue_long), .flush(flush),
        .issue_stall(stall1), .busy(busy1), .pending_cnt(cnt1)
    );

    regfile_scoreboard #(.BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_rs_use(issue_rs_use), .issue_rd_we(issue_rd_we),
        .issue_rd(issue_rd), .issue_long(issue_long), .flush(flush),
        .issue_stall(stall0), .busy(busy0), .pending_cnt(cnt0)
    );

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iv;
        logic [1:0]  use_;
        logic        rdwe;
        logic [4:0]  rd;
        logic        lng;
        logic        fl;
        logic [31:0] e_rs0;
        logic [31:0] e_rs1;
        logic        e_stall;
        logic [31:0] e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        wr_en = '0; wr_addr = '0; wr_data = '0; rs_addr = '0;
        issue_valid = 1'b0; issue_rs_use = '0; issue_rd_we = 1'b0;
        issue_rd = '0; issue_long = 1'b0; flush = 1'b0;
    endtask

    task automatic issue_long_rd(input logic [4:0] r);
        issue_valid = 1'b1; issue_rd_we = 1'b1; issue_long = 1'b1; issue_rd = r;
    endtask

    initial begin
        //          wen   wa0 wd0        wa1 wd1 ra0 ra1 iv use   we rd lng fl  rs0            rs1 stl busy           cnt
        vecs[0]  = '{2'b11, 5, A,           5, B,  5, 0, 0, 2'b00, 0, 0, 0, 0, B,             0, 0, 32'h0,        0};
        vecs[1]  = '{2'b01, 0, 32'hDEAD0000, 0, 0, 5, 0, 0, 2'b00, 0, 0, 0, 0, B,             0, 0, 32'h0,        0};
        vecs[2]  = '{2'b00, 0, 0,           0, 0,  0, 5, 0, 2'b00, 0, 0, 0, 0, 0,             B, 0, 32'h0,        0};
        vecs[3]  = '{2'b01, 7, DE,          0, 0,  7, 7, 0, 2'b00, 0, 0, 0, 0, DE,           DE, 0, 32'h0,        0};
        vecs[4]  = '{2'b00, 0, 0,           0, 0,  7, 5, 1, 2'b00, 1, 3, 1, 0, DE,            B, 0, 32'h8,        1};
        vecs[5]  = '{2'b00, 0, 0,           0, 0,  3, 5, 1, 2'b01, 0, 0, 0, 0, 0,             B, 1, 32'h8,        1};
        vecs[6]  = '{2'b00, 0, 0,           0, 0,  3, 5, 1, 2'b00, 1, 3, 0, 0, 0,             B, 1, 32'h8,        1};
        vecs[7]  = '{2'b10, 0, 0,           3, 32'h33, 3, 5, 1, 2'b01, 0, 0, 0, 0, 32'h33,    B, 0, 32'h0,        0};
        vecs[8]  = '{2'b00, 0, 0,           0, 0,  0, 0, 1, 2'b00, 1, 4, 1, 0, 0,             0, 0, 32'h10,       1};
        vecs[9]  = '{2'b01, 4, 32'h44,      0, 0,  4, 0, 1, 2'b00, 1, 4, 1, 0, 32'h44,        0, 0, 32'h10,       1};
        vecs[10] = '{2'b00, 0, 0,           0, 0,  0, 0, 1, 2'b00, 1, 1, 1, 0, 0,             0, 0, 32'h12,       2};
        vecs[11] = '{2'b00, 0, 0,           0, 0,  0, 0, 1, 2'b00, 1, 2, 1, 0, 0,             0, 0, 32'h16,       3};
        vecs[12] = '{2'b00, 0, 0,           0, 0,  0, 0, 1, 2'b00, 1, 9, 1, 0, 0,             0, 0, 32'h216,      4};
        vecs[13] = '{2'b01, 8, 32'h88,      0, 0,  0, 0, 1, 2'b00, 1, 5, 1, 1, 0,             0, 0, 32'h0,        0};
        vecs[14] = '{2'b00, 0, 0,           0, 0,  8, 5, 1, 2'b11, 1, 0, 1, 0, 32'h88,        B, 0, 32'h0,        0};
        vecs[15] = '{2'b00, 0, 0,           0, 0,  0, 0, 1, 2'b00, 1, 6, 1, 0, 0,             0, 0, 32'h40,       1};
        vecs[16] = '{2'b00, 0, 0,           0, 0,  0, 6, 1, 2'b10, 0, 0, 0, 0, 0,             0, 1, 32'h40,       1};
        vecs[17] = '{2'b00, 0, 0,           0, 0,  5, 6, 1, 2'b01, 0, 0, 0, 0, B,             0, 0, 32'h40,       1};

        // Reset, then dirty the state, then reset again with writes/issue active.
        clr_in();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hFFFF_FFFF;
        issue_long_rd(5'd9);
        tick();
        check("pre_reset busy", {32'h0, busy1}, 64'h200);
        reset = 1'b1;
        wr_addr[4:0] = 5'd6; wr_data[31:0] = 32'h123;
        issue_rd = 5'd10;
        tick();
        reset = 1'b0;
        clr_in();
        rs_addr = {5'd6, 5'd5};
        #1;
        check("reset rs_data x5/x6", rs_data1, 64'h0);
        check("reset rs_data nobypass", rs_data0, 64'h0);
        check("reset busy", {32'h0, busy1}, 64'h0);
        check("reset pending_cnt", {58'h0, cnt1}, 64'h0);
        issue_valid = 1'b1; issue_rs_use = 2'b11; rs_addr = {5'd10, 5'd9};
        issue_rd_we = 1'b1; issue_rd = 5'd9;
        #1;
        check("reset issue_stall", {63'h0, stall1}, 64'h0);
        tick();
        clr_in();

        // Table-driven vectors against the bypassing instance.
        for (int i = 0; i < 18; i++) begin
            wr_en = vecs[i].wen;
            wr_addr = {vecs[i].wa1, vecs[i].wa0};
            wr_data = {vecs[i].wd1, vecs[i].wd0};
            rs_addr = {vecs[i].ra1, vecs[i].ra0};
            issue_valid = vecs[i].iv;
            issue_rs_use = vecs[i].use_;
            issue_rd_we = vecs[i].rdwe;
            issue_rd = vecs[i].rd;
            issue_long = vecs[i].lng;
            flush = vecs[i].fl;
            #1;
            check($sformatf("v%0d rs_data0", i), {32'h0, rs_data1[31:0]}, {32'h0, vecs[i].e_rs0});
            check($sformatf("v%0d rs_data1", i), {32'h0, rs_data1[63:32]}, {32'h0, vecs[i].e_rs1});
            check($sformatf("v%0d issue_stall", i), {63'h0, stall1}, {63'h0, vecs[i].e_stall});
            tick();
            check($sformatf("v%0d busy", i), {32'h0, busy1}, {32'h0, vecs[i].e_busy});
            check($sformatf("v%0d pending_cnt", i), {58'h0, cnt1}, {58'h0, vecs[i].e_cnt});
        end
        clr_in();

        // Without bypass a same-cycle write is invisible until the next cycle.
        rs_addr = {5'd0, 5'd7};
        wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[31:0] = 32'hBEEF;
        #1;
        check("nobypass same-cycle old", {32'h0, rs_data0[31:0]}, {32'h0, DE});
        check("bypass same-cycle new", {32'h0, rs_data1[31:0]}, 64'hBEEF);
        tick();
        wr_en = 2'b00;
        #1;
        check("nobypass next-cycle new", {32'h0, rs_data0[31:0]}, 64'hBEEF);

        // Without bypass a write to a busy source does not lift the stall.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue_long_rd(5'd12);
        tick();
        clr_in();
        issue_valid = 1'b1; issue_rs_use = 2'b01; rs_addr = {5'd0, 5'd12};
        wr_en = 2'b01; wr_addr[4:0] = 5'd12; wr_data[31:0] = 32'h1212;
        #1;
        check("nobypass write-cycle stall", {63'h0, stall0}, 64'h1);
        check("bypass write-cycle stall", {63'h0, stall1}, 64'h0);
        tick();
        clr_in();
        check("nobypass busy cleared by write", {32'h0, busy0}, 64'h0);

        // Fill every register; pending_cnt peaks at NREGS-1 and x0 never sets.
        for (int r = 1; r < 32; r++) begin
            issue_long_rd(r[4:0]);
            tick();
        end
        issue_long_rd(5'd0);
        tick();
        clr_in();
        check("full busy", {32'h0, busy1}, 64'hFFFF_FFFE);
        check("full pending_cnt", {58'h0, cnt1}, 64'd31);
        check("full pending_cnt nobypass", {58'h0, cnt0}, 64'd31);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush from full busy", {32'h0, busy1}, 64'h0);
        check("flush from full cnt", {58'h0, cnt1}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
